// File: rtl/regfile_pkg.sv
// Shared widths, address-width helper and data/address typedefs for the
// multi-ported register file and its scoreboard.
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  // Number of address bits needed to index nreg registers (nreg is a power of two).
  function automatic int addr_width(input int nreg);
    int w;
    w = 0;
    while ((1 << w) < nreg) w = w + 1;
    return w;
  endfunction

  localparam int AW_DEF = addr_width(NREG_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: write-clears, issue-sets (set wins), and a registered
// pulse flagging two enabled write ports aimed at the same nonzero register.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREG = NREG_DEF,
  parameter  int NWR  = 2,
  localparam int AW   = addr_width(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_rd,
  output logic [NREG-1:0]   busy_vec,
  output logic              wr_conflict
);

  logic [NREG-1:0] busy_next;
  logic            conflict_next;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    busy_next     = busy_vec;
    conflict_next = 1'b0;
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w] && wr_addr[w*AW +: AW] != '0)
        busy_next[wr_addr[w*AW +: AW]] = 1'b0;
    end
    // Issue is applied after the clears so a same-cycle issue keeps the bit set.
    if (iss_en && iss_rd != '0)
      busy_next[iss_rd] = 1'b1;
    for (int i = 0; i < NWR; i++) begin
      for (int j = i + 1; j < NWR; j++) begin
        if (wr_en[i] && wr_en[j] && wr_addr[i*AW +: AW] == wr_addr[j*AW +: AW]
            && wr_addr[i*AW +: AW] != '0)
          conflict_next = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_vec    <= '0;
      wr_conflict <= 1'b0;
    end else begin
      busy_vec    <= busy_next;
      wr_conflict <= conflict_next;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with x0 hardwired to zero and a busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN = XLEN_DEF,
  parameter  int NREG = NREG_DEF,
  parameter  int NRD  = 2,
  parameter  int NWR  = 2,
  localparam int AW   = addr_width(NREG)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NRD*AW-1:0]   i_rs_addr,
  output logic [NRD*XLEN-1:0] o_rs_val,
  output logic [NRD-1:0]      o_rs_busy,
  input  logic [NWR-1:0]      i_wr_en,
  input  logic [NWR*AW-1:0]   i_wr_addr,
  input  logic [NWR*XLEN-1:0] i_wr_data,
  input  logic                i_iss_en,
  input  logic [AW-1:0]       i_iss_rd,
  output logic [NREG-1:0]     o_busy_vec,
  output logic                o_wr_conflict
);

  logic [XLEN-1:0] mem [NREG];

  // NOTE: this memory is reset because every register must read back 0 after
  // reset; storage without that requirement should stay unreset so it can map to RAM.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int r = 0; r < NREG; r++) mem[r] <= '0;
    end else begin
      // Ports are visited in ascending order; the last scheduled update to an
      // address takes effect, so the highest-index port wins a collision.
      for (int w = 0; w < NWR; w++) begin
        if (i_wr_en[w] && i_wr_addr[w*AW +: AW] != '0)
          mem[i_wr_addr[w*AW +: AW]] <= i_wr_data[w*XLEN +: XLEN];
      end
    end
  end

  regfile_scoreboard #(
    .NREG (NREG),
    .NWR  (NWR)
  ) u_scoreboard (
    .clk         (i_clk),
    .rst         (i_rst),
    .wr_en       (i_wr_en),
    .wr_addr     (i_wr_addr),
    .iss_en      (i_iss_en),
    .iss_rd      (i_iss_rd),
    .busy_vec    (o_busy_vec),
    .wr_conflict (o_wr_conflict)
  );

  always_comb begin : read_ports
    logic [AW-1:0] ra;
`ifdef REGFILE_BYPASS_EN
    logic          hit;
`endif
    o_rs_val  = '0;
    o_rs_busy = '0;
    for (int p = 0; p < NRD; p++) begin
      ra = i_rs_addr[p*AW +: AW];
      if (ra != '0) begin
        o_rs_val[p*XLEN +: XLEN] = mem[ra];
        o_rs_busy[p]             = o_busy_vec[ra];
`ifdef REGFILE_BYPASS_EN
        hit = 1'b0;
        for (int w = 0; w < NWR; w++) begin
          if (i_wr_en[w] && i_wr_addr[w*AW +: AW] == ra) begin
            o_rs_val[p*XLEN +: XLEN] = i_wr_data[w*XLEN +: XLEN];
            hit                      = 1'b1;
          end
        end
        if (hit)
          o_rs_busy[p] = i_iss_en && (i_iss_rd == ra);
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp: vector table plus hand-written
// sequences for collisions, scoreboard timing, bypass and reset.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int AW   = 5;

  logic                clk;
  logic                rst;
  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD*XLEN-1:0] rs_val;
  logic [NRD-1:0]      rs_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_rd;
  logic [NREG-1:0]     busy_vec;
  logic                wr_conflict;

  regfile_mp #(
    .XLEN (XLEN),
    .NREG (NREG),
    .NRD  (NRD),
    .NWR  (NWR)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_rs_addr     (rs_addr),
    .o_rs_val      (rs_val),
    .o_rs_busy     (rs_busy),
    .i_wr_en       (wr_en),
    .i_wr_addr     (wr_addr),
    .i_wr_data     (wr_data),
    .i_iss_en      (iss_en),
    .i_iss_rd      (iss_rd),
    .o_busy_vec    (busy_vec),
    .o_wr_conflict (wr_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0] en;
    reg_addr_t  wa0;
    reg_data_t  wd0;
    reg_addr_t  wa1;
    reg_data_t  wd1;
    reg_addr_t  ra0;
    reg_addr_t  ra1;
    reg_data_t  ev0;
    reg_data_t  ev1;
    logic       econf;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input logic [1:0] en, input reg_addr_t wa0, input reg_data_t wd0,
                              input reg_addr_t wa1, input reg_data_t wd1,
                              input reg_addr_t ra0, input reg_addr_t ra1,
                              input reg_data_t ev0, input reg_data_t ev1, input logic econf);
    vec_t v;
    v.en = en; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.ra0 = ra0; v.ra1 = ra1; v.ev0 = ev0; v.ev1 = ev1; v.econf = econf;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en  = '0;
    iss_en = 1'b0;
    iss_rd = '0;
  endtask

  task automatic drive_wr(input int port, input reg_addr_t a, input reg_data_t d);
    wr_en[port]                 = 1'b1;
    wr_addr[port*AW +: AW]      = a;
    wr_data[port*XLEN +: XLEN]  = d;
  endtask

  task automatic set_rd(input reg_addr_t a0, input reg_addr_t a1);
    rs_addr = {a1, a0};
  endtask

  initial begin
    // Expected values observed during each row's cycle, i.e. before its own edge.
    vecs[0]  = mk(2'b01, 5'd5,  32'hDEADBEEF, 5'd0,  32'h0,        5'd0,  5'd1,  32'h0,        32'h0,        1'b0);
    vecs[1]  = mk(2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        1'b0);
    vecs[2]  = mk(2'b01, 5'd0,  32'h12345678, 5'd0,  32'h0,        5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 1'b0);
    vecs[3]  = mk(2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 1'b0);
    vecs[4]  = mk(2'b11, 5'd7,  32'h1,        5'd7,  32'h2,        5'd6,  5'd5,  32'h0,        32'hDEADBEEF, 1'b0);
    vecs[5]  = mk(2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd7,  5'd6,  32'h2,        32'h0,        1'b1);
    vecs[6]  = mk(2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd7,  5'd5,  32'h2,        32'hDEADBEEF, 1'b0);
    vecs[7]  = mk(2'b11, 5'd10, 32'hAAAA0000, 5'd11, 32'h0000BBBB, 5'd1,  5'd2,  32'h0,        32'h0,        1'b0);
    vecs[8]  = mk(2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd10, 5'd11, 32'hAAAA0000, 32'h0000BBBB, 1'b0);
    vecs[9]  = mk(2'b11, 5'd0,  32'h1,        5'd0,  32'h2,        5'd7,  5'd0,  32'h2,        32'h0,        1'b0);
    vecs[10] = mk(2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd0,  5'd11, 32'h0,        32'h0000BBBB, 1'b0);
    vecs[11] = mk(2'b01, 5'd12, 32'h55,       5'd5,  32'hFFFFFFFF, 5'd5,  5'd10, 32'hDEADBEEF, 32'hAAAA0000, 1'b0);
    vecs[12] = mk(2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd5,  5'd12, 32'hDEADBEEF, 32'h55,       1'b0);
    vecs[13] = mk(2'b11, 5'd10, 32'h3,        5'd10, 32'h4,        5'd12, 5'd0,  32'h55,       32'h0,        1'b0);
    vecs[14] = mk(2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd10, 5'd11, 32'h4,        32'h0000BBBB, 1'b1);

    rst = 1'b1;
    idle();
    wr_addr = '0;
    wr_data = '0;
    set_rd(5'd0, 5'd0);
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    set_rd(5'd5, 5'd7);
    #1;
    check("reset val0", rs_val[31:0], 64'h0);
    check("reset val1", rs_val[63:32], 64'h0);
    check("reset rs_busy", rs_busy, 64'h0);
    check("reset busy_vec", busy_vec, 64'h0);
    check("reset conflict", wr_conflict, 64'h0);
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      wr_en   = vecs[i].en;
      wr_addr = {vecs[i].wa1, vecs[i].wa0};
      wr_data = {vecs[i].wd1, vecs[i].wd0};
      iss_en  = 1'b0;
      set_rd(vecs[i].ra0, vecs[i].ra1);
      #1;
      check($sformatf("row%0d val0", i), rs_val[31:0], vecs[i].ev0);
      check($sformatf("row%0d val1", i), rs_val[63:32], vecs[i].ev1);
      check($sformatf("row%0d conflict", i), wr_conflict, vecs[i].econf);
      check($sformatf("row%0d busy_vec", i), busy_vec, 64'h0);
      step();
    end

    // Issue to x0 is ignored.
    idle();
    iss_en = 1'b1;
    iss_rd = 5'd0;
    step();
    idle();
    set_rd(5'd0, 5'd9);
    #1;
    check("iss x0 busy_vec", busy_vec, 64'h0);
    check("iss x0 rs_busy", rs_busy, 64'h0);
    @(negedge clk);

    // Issue x9, three idle cycles, then a write clears it: busy for 4 cycles.
    iss_en = 1'b1;
    iss_rd = 5'd9;
    step();
    for (int k = 0; k < 4; k++) begin
      idle();
      if (k == 3) drive_wr(0, 5'd9, 32'h99);
      #1;
      check($sformatf("busy9 cyc%0d", k + 1), busy_vec[9], 64'h1);
      if (k < 3) check($sformatf("rs_busy9 cyc%0d", k + 1), rs_busy[1], 64'h1);
      @(negedge clk);
    end
    step();
    idle();
    #1;
    check("busy9 cleared", busy_vec[9], 64'h0);
    check("x9 after write", rs_val[63:32], 64'h99);
    @(negedge clk);

    // Same-cycle issue and write to x9: set wins, data still stored.
    drive_wr(1, 5'd9, 32'h77);
    iss_en = 1'b1;
    iss_rd = 5'd9;
    step();
    idle();
    #1;
    check("iss+wr busy9", busy_vec[9], 64'h1);
    check("iss+wr x9 data", rs_val[63:32], 64'h77);
    @(negedge clk);
    drive_wr(0, 5'd9, 32'h78);
    step();
    idle();
    #1;
    check("x9 released", busy_vec, 64'h0);
    @(negedge clk);

    // Read of a register being written in the same cycle.
    drive_wr(0, 5'd3, 32'h11);
    step();
    idle();
    drive_wr(1, 5'd3, 32'hA5A5A5A5);
    set_rd(5'd3, 5'd0);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass x3 val", rs_val[31:0], 64'hA5A5A5A5);
`else
    check("no-bypass x3 val", rs_val[31:0], 64'h11);
`endif
    check("same-cycle x3 busy", rs_busy[0], 64'h0);
    step();
    idle();
    #1;
    check("x3 after edge", rs_val[31:0], 64'hA5A5A5A5);
    @(negedge clk);

    // Fill x1..x31, mark a few busy, then reset alongside a conflicting write.
    for (int r = 1; r < 32; r++) begin
      idle();
      drive_wr(0, reg_addr_t'(r), 32'h1000_0000 + r);
      step();
    end
    idle();
    iss_en = 1'b1; iss_rd = 5'd4;  step();
    iss_en = 1'b1; iss_rd = 5'd20; step();
    iss_en = 1'b1; iss_rd = 5'd31; step();
    idle();
    set_rd(5'd1, 5'd31);
    #1;
    check("preload busy_vec", busy_vec, 64'h8010_0010);
    check("preload x1", rs_val[31:0], 64'h1000_0001);
    check("preload x31", rs_val[63:32], 64'h1000_001F);
    @(negedge clk);
    rst = 1'b1;
    drive_wr(0, 5'd8, 32'hCAFE0001);
    drive_wr(1, 5'd8, 32'hCAFE0002);
    iss_en = 1'b1;
    iss_rd = 5'd2;
    step();
    rst = 1'b0;
    idle();
    #1;
    check("post-rst busy_vec", busy_vec, 64'h0);
    check("post-rst conflict", wr_conflict, 64'h0);
    for (int r = 0; r < 32; r += 2) begin
      set_rd(reg_addr_t'(r), reg_addr_t'(r + 1));
      #1;
      check($sformatf("post-rst x%0d", r), rs_val[31:0], 64'h0);
      check($sformatf("post-rst x%0d", r + 1), rs_val[63:32], 64'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning register data width in bits.
REQ-002 SHALL have parameter NREG, default 32, meaning architectural register count, power of two, at least 2; AW = log2(NREG).
REQ-003 SHALL have parameter NRD, default 2, meaning read port count, 1..4.
REQ-004 SHALL have parameter NWR, default 2, meaning write port count, 1..4.
REQ-005 SHALL have port i_clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-006 SHALL have port i_rst, input, 1 bit, meaning reset, synchronous and active-high.
REQ-007 SHALL have port i_rs_addr, input, NRD x AW, meaning the read address per read port.
REQ-008 SHALL have port o_rs_val, output, NRD x XLEN, meaning the read data per read port.
REQ-009 SHALL have port o_rs_busy, output, NRD, meaning the scoreboard busy bit of each read address.
REQ-010 SHALL have port i_wr_en, input, NWR, meaning the write enable per write port.
REQ-011 SHALL have port i_wr_addr, input, NWR x AW, meaning the write address per write port.
REQ-012 SHALL have port i_wr_data, input, NWR x XLEN, meaning the write data per write port.
REQ-013 SHALL have port i_iss_en, input, 1 bit, meaning issue strobe: mark i_iss_rd pending.
REQ-014 SHALL have port i_iss_rd, input, AW, meaning the destination register being issued.
REQ-015 SHALL have port o_busy_vec, output, NREG, meaning the registered scoreboard vector.
REQ-016 SHALL have port o_wr_conflict, output, 1 bit, meaning a registered one-cycle pulse when two or more enabled write ports target the same nonzero register.

Function
REQ-017 SHALL combinationally read: o_rs_val[p] = storage[i_rs_addr[p]], with zero latency.
REQ-018 SHALL return 0 and busy = 0 for address 0 on every read port; writes and issues to register 0 are ignored.
REQ-019 SHALL update storage on the clock edge for each write port with i_wr_en = 1 and a nonzero address.
REQ-020 SHALL resolve a same-address write collision so that the highest-index write port wins, and SHALL assert o_wr_conflict in the following cycle.
REQ-021 SHALL clear the busy bit of the target register on each enabled nonzero write.
REQ-022 SHALL set the busy bit of i_iss_rd on the clock edge when i_iss_en = 1 and i_iss_rd is not 0.
REQ-023 SHALL let set win when an issue and a write hit the same register in one cycle: the busy bit ends at 1 and storage still takes the write data.
REQ-024 SHALL have o_rs_busy[p] = o_busy_vec[i_rs_addr[p]], reflecting the registered state only.
REQ-025 SHALL leave storage and scoreboard unchanged in a cycle with no writes and no issue.

Reset
REQ-026 SHALL, while i_rst = 1 at a clock edge, clear all storage to 0, clear o_busy_vec to 0, and clear o_wr_conflict to 0; reset has priority over same-cycle writes and issues.
REQ-027 SHALL have outputs after reset of o_rs_val = 0, o_rs_busy = 0, o_busy_vec = 0, and o_wr_conflict = 0.
REQ-028 SHALL discard writes and issues presented during the reset cycle; pending busy bits are lost.

Configuration
REQ-029 SHALL, when REGFILE_BYPASS_EN is defined, forward any same-cycle enabled nonzero write whose address matches i_rs_addr[p] to o_rs_val[p], using the highest-index matching port; o_rs_busy[p] then reads 0 for that register unless an issue targets it in the same cycle.
REQ-030 SHALL, when REGFILE_BYPASS_EN is not defined, return the pre-edge stored value and the registered busy bit, with no forwarding.

Structure
REQ-031 SHALL place the default XLEN, the default NREG, the AW derivation function, and the reg_addr_t and reg_data_t typedefs in the shared package regfile_pkg.
REQ-032 SHALL implement the busy vector, the set/clear priority, and the conflict detection in the sub-module regfile_scoreboard, instantiated once.

Verification
REQ-033 SHALL cover: reset, then a write of 0xDEADBEEF to x5 on port 0 -> the next cycle, a read of x5 returns 0xDEADBEEF and busy = 0.
REQ-034 SHALL cover: a write of 0x12345678 to x0 -> a read of x0 returns 0 and o_wr_conflict = 0.
REQ-035 SHALL cover: port 0 writes 0x1 and port 1 writes 0x2 to x7 in the same cycle -> x7 reads 0x2 and o_wr_conflict pulses high for exactly one cycle.
REQ-036 SHALL cover: issue x9, then idle 3 cycles, then a write to x9 -> o_busy_vec[9] is 1 for 4 cycles and 0 after; an issue and a write to x9 in the same cycle -> o_busy_vec[9] stays 1.
REQ-037 SHALL cover, with the macro on: write 0xA5A5A5A5 to x3 while reading x3 -> o_rs_val = 0xA5A5A5A5 in the same cycle; with the macro off -> the old value is returned.
REQ-038 SHALL cover: load x1..x31 with nonzero values and set several busy bits, then assert i_rst for 1 cycle alongside a write -> all registers read 0, o_busy_vec = 0, and the write is discarded.
